// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared definitions for the register-transfer sequencer: op codes, register ids,
// sequencer states and the request decode helpers used by decoder and controller.
package reg_xfer_ctrl_pkg;

    localparam int XFER_W = 8;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_X = 2'd1;
    localparam logic [1:0] REG_Y = 2'd2;
    localparam logic [1:0] REG_S = 2'd3;

    typedef enum logic [1:0] {
        OP_MOVE = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_BAD  = 2'b11
    } xfer_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2
    } xfer_state_e;

    typedef struct packed {
        xfer_op_e   op;
        logic [1:0] src;
        logic [1:0] dst;
    } xfer_req_t;

    function automatic logic f_req_valid(input logic [1:0] op,
                                         input logic [2:0] src,
                                         input logic [2:0] dst);
        return (op != 2'b11) && (src[2] == 1'b0) && (dst[2] == 1'b0);
    endfunction

    function automatic logic [3:0] f_ce_decode(input logic [1:0] id);
        logic [3:0] v;
        case (id)
            REG_A:   v = 4'b0001;
            REG_X:   v = 4'b0010;
            REG_Y:   v = 4'b0100;
            REG_S:   v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Request/response and register-file side signals of the transfer sequencer.
interface reg_xfer_ctrl_if #(parameter int WIDTH = 8);

    logic             req;
    logic [1:0]       op;
    logic [2:0]       src;
    logic [2:0]       dst;
    logic [WIDTH-1:0] bus;
    logic             ack;
    logic             err;
    logic             busy;
    logic [2:0]       sel;
    logic [WIDTH-1:0] res;
    logic [3:0]       ce;
    logic             flag_ce;
    logic             n_flag;
    logic             z_flag;
    logic             done;

    modport master (
        output req, op, src, dst, bus,
        input  ack, err, busy, sel, res, ce, flag_ce, n_flag, z_flag, done
    );

    modport slave (
        input  req, op, src, dst, bus,
        output ack, err, busy, sel, res, ce, flag_ce, n_flag, z_flag, done
    );

endinterface

// File: rtl/reg_xfer_ctrl_register.sv
// Plain clock-enabled register with synchronous clear; holds the bus sample T.
module reg_xfer_ctrl_register #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // storage: clear on reset, load when enabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Three-state sequencer for MOVE/INC/DEC register transfers: drives the bus select,
// the destination clock enable and the N/Z flag update for one request at a time.
module reg_xfer_ctrl
    import reg_xfer_ctrl_pkg::*;
#(
    parameter int WIDTH = XFER_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    reg_xfer_ctrl_if.slave bus_if
);

    localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    xfer_state_e      r_state;
    xfer_state_e      w_state_nxt;
    xfer_req_t        r_req;
    logic             r_ack;
    logic             r_err;
    logic             r_done;
    logic [WIDTH-1:0] r_res_hold;
    logic             r_n_hold;
    logic             r_z_hold;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_res;
    logic             w_accept;
    logic             w_reject;
    logic             w_drive;
    logic             w_write;

    assign w_drive = (r_state == ST_DRIVE);
    assign w_write = (r_state == ST_WRITE);

    reg_xfer_ctrl_register #(.WIDTH(WIDTH)) u_t_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_ce  (w_drive),
        .i_d   (bus_if.bus),
        .o_q   (w_t)
    );

    // next-state and request accept/reject decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_if.req) begin
                    if (f_req_valid(bus_if.op, bus_if.src, bus_if.dst)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_DRIVE;
                    end else begin
                        w_reject    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // capture the accepted request; the decoder may change its fields right after ACK
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req <= '{op: OP_MOVE, src: 2'd0, dst: 2'd0};
        end else if (w_accept) begin
            r_req <= '{op: xfer_op_e'(bus_if.op), src: bus_if.src[1:0], dst: bus_if.dst[1:0]};
        end
    end

    // one-cycle handshake pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_err  <= w_reject;
            r_done <= w_write;
        end
    end

    // inc/dec adder on the sampled bus value, wrapping modulo 2^WIDTH
    always_comb begin
        w_res = w_t;
        case (r_req.op)
            OP_MOVE: w_res = w_t;
            OP_INC:  w_res = w_t + LSB_ONE;
            OP_DEC:  w_res = w_t - LSB_ONE;
            default: w_res = w_t;
        endcase
    end

    // RES and flags keep the last written value once the sequence leaves WRITE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_hold <= {WIDTH{1'b0}};
            r_n_hold   <= 1'b0;
            r_z_hold   <= 1'b0;
        end else if (w_write) begin
            r_res_hold <= w_res;
            r_n_hold   <= w_res[WIDTH-1];
            r_z_hold   <= (w_res == {WIDTH{1'b0}});
        end
    end

    assign bus_if.ack     = r_ack;
    assign bus_if.err     = r_err;
    assign bus_if.done    = r_done;
    assign bus_if.busy    = w_drive | w_write;
    assign bus_if.sel     = (w_drive | w_write) ? {1'b0, r_req.src} : 3'd0;
    // write strobes are gated by reset so a reset in WRITE never lands a partial update
    assign bus_if.ce      = (w_write && !i_rst) ? f_ce_decode(r_req.dst) : 4'b0000;
    assign bus_if.flag_ce = w_write && !i_rst && (r_req.dst != REG_S);
    assign bus_if.res     = w_write ? w_res : r_res_hold;
    assign bus_if.n_flag  = w_write ? w_res[WIDTH-1] : r_n_hold;
    assign bus_if.z_flag  = w_write ? (w_res == {WIDTH{1'b0}}) : r_z_hold;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl: cycle-indexed expectation model plus literal checks.
module tb_reg_xfer_ctrl;

    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_xfer_ctrl_if #(.WIDTH(8)) u_if ();

    reg_xfer_ctrl #(.WIDTH(8)) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus_if (u_if.slave)
    );

    always #5 clk = ~clk;

    // expected outputs, indexed by cycle number (cycle n starts at the n-th rising edge)
    logic       e_ack  [MAXC];
    logic       e_err  [MAXC];
    logic       e_busy [MAXC];
    logic       e_done [MAXC];
    logic       e_fce  [MAXC];
    logic [2:0] e_sel  [MAXC];
    logic [3:0] e_ce   [MAXC];
    logic [7:0] e_res  [MAXC];
    logic       e_n    [MAXC];
    logic       e_z    [MAXC];

    int       cyc = 0;
    int       next_free = 0;
    int       pend = -1;
    bit       seen_rst = 1'b0;
    logic [1:0] m_op;
    logic [1:0] m_src;
    logic [1:0] m_dst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic void clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_ack[i] = 1'b0;  e_err[i] = 1'b0;  e_busy[i] = 1'b0; e_done[i] = 1'b0;
            e_fce[i] = 1'b0;  e_sel[i] = 3'd0;  e_ce[i] = 4'd0;   e_res[i] = 8'd0;
            e_n[i] = 1'b0;    e_z[i] = 1'b0;
        end
    endfunction

    function automatic void fill_res(input int c, input logic [7:0] v);
        for (int i = c; i < MAXC; i++) begin
            e_res[i] = v;
            e_n[i]   = (v >= 8'd128);
            e_z[i]   = (v == 8'd0);
        end
    endfunction

    // reference model: follows the request/transfer rules at each rising edge
    always @(posedge clk) begin
        logic [7:0] v;
        cyc = cyc + 1;
        if (cyc < MAXC - 4) begin
            if (rst) begin
                clear_from(cyc);
                next_free = cyc + 1;
                pend      = -1;
                seen_rst  = 1'b1;
            end else begin
                if (pend == cyc) begin
                    case (m_op)
                        2'd1:    v = u_if.bus + 8'd1;
                        2'd2:    v = u_if.bus - 8'd1;
                        default: v = u_if.bus;
                    endcase
                    e_busy[cyc]   = 1'b1;
                    e_sel[cyc]    = {1'b0, m_src};
                    e_ce[cyc]     = 4'b0001 << m_dst;
                    e_fce[cyc]    = (m_dst != 2'd3);
                    fill_res(cyc, v);
                    e_done[cyc+1] = 1'b1;
                    pend = -1;
                end
                if (cyc >= next_free && u_if.req) begin
                    if (u_if.op != 2'b11 && u_if.src < 3'd4 && u_if.dst < 3'd4) begin
                        e_ack[cyc]  = 1'b1;
                        e_busy[cyc] = 1'b1;
                        e_sel[cyc]  = u_if.src;
                        m_op  = u_if.op;
                        m_src = u_if.src[1:0];
                        m_dst = u_if.dst[1:0];
                        pend      = cyc + 1;
                        next_free = cyc + 3;
                    end else begin
                        e_err[cyc] = 1'b1;
                        next_free  = cyc + 1;
                    end
                end
            end
        end
    end

    // every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (seen_rst && cyc < MAXC) begin
            chk("m_ack",  u_if.ack,     e_ack[cyc]);
            chk("m_err",  u_if.err,     e_err[cyc]);
            chk("m_busy", u_if.busy,    e_busy[cyc]);
            chk("m_done", u_if.done,    e_done[cyc]);
            chk("m_sel",  u_if.sel,     e_sel[cyc]);
            chk("m_ce",   u_if.ce,      rst ? 4'd0 : e_ce[cyc]);
            chk("m_fce",  u_if.flag_ce, rst ? 1'b0 : e_fce[cyc]);
            chk("m_res",  u_if.res,     e_res[cyc]);
            chk("m_n",    u_if.n_flag,  e_n[cyc]);
            chk("m_z",    u_if.z_flag,  e_z[cyc]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [7:0] bus, input logic [7:0] x_res, input logic [3:0] x_ce,
                        input logic x_fce, input logic x_n, input logic x_z);
        u_if.req = 1'b1; u_if.op = op; u_if.src = src; u_if.dst = dst;
        tick();
        chk("x_ack", u_if.ack, 1'b1);
        u_if.req = 1'b0; u_if.bus = bus;
        tick();
        chk("x_res", u_if.res, x_res);
        chk("x_ce",  u_if.ce, x_ce);
        chk("x_fce", u_if.flag_ce, x_fce);
        chk("x_n",   u_if.n_flag, x_n);
        chk("x_z",   u_if.z_flag, x_z);
        tick();
        chk("x_done", u_if.done, 1'b1);
    endtask

    initial begin
        u_if.req = 1'b0; u_if.op = 2'd0; u_if.src = 3'd0; u_if.dst = 3'd0; u_if.bus = 8'd0;
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_ack",  u_if.ack, 1'b0);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_res",  u_if.res, 8'h00);
        chk("rst_z",    u_if.z_flag, 1'b0);
        chk("rst_ce",   u_if.ce, 4'b0000);

        xfer(2'b00, 3'd0, 3'd1, 8'h80, 8'h80, 4'b0010, 1'b1, 1'b1, 1'b0);
        xfer(2'b01, 3'd1, 3'd1, 8'hFF, 8'h00, 4'b0010, 1'b1, 1'b0, 1'b1);
        xfer(2'b10, 3'd2, 3'd2, 8'h00, 8'hFF, 4'b0100, 1'b1, 1'b1, 1'b0);
        xfer(2'b00, 3'd1, 3'd3, 8'h00, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b1);
        xfer(2'b00, 3'd3, 3'd1, 8'h5A, 8'h5A, 4'b0010, 1'b1, 1'b0, 1'b0);

        // invalid op, then invalid source: one ERR pulse each
        u_if.req = 1'b1; u_if.op = 2'b11; u_if.src = 3'd0; u_if.dst = 3'd1;
        tick();
        chk("err_op", u_if.err, 1'b1);
        chk("err_op_ack", u_if.ack, 1'b0);
        u_if.req = 1'b0;
        tick();
        chk("err_op_pulse", u_if.err, 1'b0);
        u_if.req = 1'b1; u_if.op = 2'b00; u_if.src = 3'd5;
        tick();
        chk("err_src", u_if.err, 1'b1);
        chk("err_src_busy", u_if.busy, 1'b0);
        u_if.req = 1'b0;
        tick();

        // request held through BUSY: next accept lands exactly 3 cycles later
        u_if.req = 1'b1; u_if.op = 2'b00; u_if.src = 3'd0; u_if.dst = 3'd2;
        tick();
        chk("hold_ack1", u_if.ack, 1'b1);
        u_if.op = 2'b01; u_if.src = 3'd2; u_if.dst = 3'd0; u_if.bus = 8'h10;
        tick();
        chk("hold_res1", u_if.res, 8'h10);
        chk("hold_ce1",  u_if.ce, 4'b0100);
        tick();
        chk("hold_done1", u_if.done, 1'b1);
        chk("hold_noack", u_if.ack, 1'b0);
        tick();
        chk("hold_ack2", u_if.ack, 1'b1);
        u_if.req = 1'b0; u_if.bus = 8'h7F;
        tick();
        chk("hold_res2", u_if.res, 8'h80);
        chk("hold_ce2",  u_if.ce, 4'b0001);
        tick();

        // reset during WRITE blocks the write and the DONE pulse
        u_if.req = 1'b1; u_if.op = 2'b00; u_if.src = 3'd0; u_if.dst = 3'd2;
        tick();
        u_if.req = 1'b0; u_if.bus = 8'h33;
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_ce",  u_if.ce, 4'b0000);
        chk("rstw_fce", u_if.flag_ce, 1'b0);
        tick();
        rst = 1'b0;
        chk("rstw_done", u_if.done, 1'b0);
        chk("rstw_res",  u_if.res, 8'h00);
        chk("rstw_busy", u_if.busy, 1'b0);

        // reset during DRIVE aborts the sequence
        u_if.req = 1'b1; u_if.op = 2'b01; u_if.src = 3'd1; u_if.dst = 3'd1;
        tick();
        u_if.req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rstd_done", u_if.done, 1'b0);
        chk("rstd_busy", u_if.busy, 1'b0);

        xfer(2'b01, 3'd0, 3'd0, 8'h7F, 8'h80, 4'b0001, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_xfer_ctrl.md
# reg_xfer_ctrl

Sequencer for register-to-register transfers in the 65C02 core: takes one transfer request (MOVE, INC or DEC from a source register to a destination register) and drives the internal-bus source select, the destination register's clock enable and the N/Z flag update over a fixed three-state sequence. Sits between the instruction decoder (requester) and the A/X/Y/S `register` instances plus the internal bus mux. It covers TAX/TXA/TAY/TYA/TSX/TXS and INX/INY/DEX/DEY.

## Interface
- WIDTH, 8, data width of registers, bus and result
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-high
- REQ  in  1  transfer request; held by requester until ACK
- OP  in  2  00 MOVE, 01 INC, 10 DEC, 11 invalid
- SRC  in  3  source register id: 0 A, 1 X, 2 Y, 3 S; 4-7 invalid
- DST  in  3  destination register id, same encoding
- BUS  in  WIDTH  internal bus value, driven by the mux selected by SEL
- ACK  out  1  one-cycle pulse: request accepted
- ERR  out  1  one-cycle pulse: request rejected (invalid OP/SRC/DST)
- BUSY  out  1  high in DRIVE and WRITE
- SEL  out  3  bus mux source select
- RES  out  WIDTH  value presented to destination register inputs
- CE  out  4  one-hot clock enable, bit n = register id n
- FLAG_CE  out  1  N/Z flag update enable
- N_FLAG  out  1  RES[WIDTH-1]
- Z_FLAG  out  1  RES == 0
- DONE  out  1  one-cycle pulse: write completed

## Operation
- States: IDLE, DRIVE, WRITE. Encoding is free; IDLE on reset.
- IDLE: at an edge with REQ=1, check validity.
  - Valid: latch OP/SRC/DST, go to DRIVE, assert ACK for one cycle.
  - Invalid: stay IDLE, assert ERR for one cycle, no ACK.
- DRIVE: SEL = latched SRC. At the closing edge, holding register T <= BUS, then go to WRITE.
- WRITE:
  - RES = T (MOVE), T+1 (INC) or T-1 (DEC), all modulo 2^WIDTH.
  - CE[DST] = 1, all other CE bits 0.
  - FLAG_CE = 1 unless DST == 3 (S); TXS leaves flags alone.
  - N_FLAG and Z_FLAG are taken from RES.
  - Go to IDLE; DONE = 1 in the next cycle.
- SRC == DST is legal (for example INX as X->X INC). The flags update normally.
- REQ seen outside IDLE is ignored. There is no queue.
- SEL = 0 and CE = 0 outside DRIVE/WRITE. RES, N_FLAG and Z_FLAG hold their last value.
- Wrap-around: INC of {WIDTH{1}} gives 0 with Z=1. DEC of 0 gives {WIDTH{1}} with N=1.

## Timing
- Reset values: ACK, ERR, DONE, BUSY, FLAG_CE, N_FLAG, Z_FLAG = 0. SEL = 0, CE = 0, RES = 0, T = 0.
- Request accepted at edge k. ACK and BUSY are high in cycle k+1 (DRIVE). Cycle k+2 is WRITE. The destination captures at the end of k+2. DONE is high in cycle k+3 (IDLE).
- Throughput: a new REQ may be accepted in the DONE cycle, so there is one transfer per 3 cycles.
- CE and FLAG_CE are gated combinationally by ~RST. RST high during WRITE therefore blocks the write: no partial update, no DONE, next state IDLE.
- RST during DRIVE aborts the sequence. T is cleared and no ACK or DONE follows.
- ERR is asserted in the cycle after the rejecting edge. ERR and ACK are never high together.

## Structure
- Shared header `reg_ctrl_defs.vh` holds:
  - register ids (REG_A/X/Y/S)
  - op codes (OP_MOVE/INC/DEC)
  - state encodings
- The decoder and the bus mux also include this header.
- Sub-module: T is an instance of the existing `register` (WIDTH, CE = state==DRIVE).
- The FSM, inc/dec adder, CE decode and flag logic stay in reg_xfer_ctrl.

## Test plan
- Reset, then REQ MOVE SRC=0 DST=1 with BUS=8'h80 during DRIVE -> ACK in cycle 1; WRITE with RES=8'h80, CE=4'b0010, FLAG_CE=1, N=1, Z=0; DONE in cycle 3.
- INC SRC=1 DST=1, BUS=8'hFF -> RES=8'h00, CE=4'b0010, Z=1, N=0. Then DEC SRC=2 DST=2, BUS=8'h00 -> RES=8'hFF, N=1.
- MOVE SRC=1 DST=3, BUS=8'h00 -> CE=4'b1000, FLAG_CE=0. Then MOVE SRC=3 DST=1 -> FLAG_CE=1.
- OP=11, then SRC=5 -> one ERR pulse each; no ACK, BUSY, CE or DONE.
- Second REQ held during BUSY -> ignored until the DONE cycle, accepted there; ACK spacing is exactly 3 cycles.
- RST raised during WRITE of MOVE 0->2 -> CE stays 0 that cycle, no DONE, all outputs at reset values the next cycle.
